// File: rtl/lvds_align_ctrl.sv
// lvds_align_ctrl: per-lane word-alignment sequencer for the 7:1 LVDS rx path.
// Optional LVDS_ALIGN_RETRY_EN: re-run failed sequences up to 3 times.
module lvds_align_ctrl #(
  parameter int         NUM_CH        = 4,
  parameter logic [6:0] TRAIN_PATTERN = 7'b110_0011,
  parameter int         MATCH_CNT     = 4,
  parameter int         SLIP_WAIT     = 6
) (
  input  logic                px_clk,
  input  logic                px_reset_n,
  input  logic                px_ready,
  input  logic [7*NUM_CH-1:0] lane_data,
  output logic [NUM_CH-1:0]   slip,
  output logic [2:0]          cur_lane,
  output logic                align_busy,
  output logic                align_done,
  output logic [NUM_CH-1:0]   lane_ok,
  output logic [NUM_CH-1:0]   lane_fail
`ifdef LVDS_ALIGN_RETRY_EN
  ,
  output logic [1:0]          retry_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    NEXT,
    DONE
  } state_t;

  state_t              state_q;
  logic [NUM_CH-1:0]   slip_q;
  logic [2:0]          cur_lane_q;
  logic                busy_q;
  logic                done_q;
  logic [NUM_CH-1:0]   ok_q;
  logic [NUM_CH-1:0]   fail_q;
  logic [3:0]          match_cnt_q;
  logic [2:0]          slip_cnt_q;
  logic [3:0]          wait_cnt_q;
`ifdef LVDS_ALIGN_RETRY_EN
  logic [1:0]          retry_q;
`endif

  logic [6:0]          cur_word_d;
  logic                match_d;
  logic                last_d;
  logic [NUM_CH-1:0]   mask_d;

  // Select the gearbox word of the lane under alignment.
  always_comb begin
    cur_word_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_lane_q == 3'(k)) cur_word_d = lane_data[7*k +: 7];
    end
  end

  assign match_d = (cur_word_d == TRAIN_PATTERN);
  assign last_d  = (cur_lane_q == 3'(NUM_CH-1));
  assign mask_d  = NUM_CH'(1) << cur_lane_q;

  // Alignment sequencer; every output comes straight from a register.
  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      state_q     <= IDLE;
      slip_q      <= '0;
      cur_lane_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= '0;
      fail_q      <= '0;
      match_cnt_q <= '0;
      slip_cnt_q  <= '0;
      wait_cnt_q  <= '0;
`ifdef LVDS_ALIGN_RETRY_EN
      retry_q     <= '0;
`endif
    end else if (state_q != IDLE && !px_ready) begin
      state_q <= IDLE;
      slip_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= '0;
      fail_q  <= '0;
`ifdef LVDS_ALIGN_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (px_ready) begin
            ok_q        <= '0;
            fail_q      <= '0;
            cur_lane_q  <= '0;
            slip_cnt_q  <= '0;
            match_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          if (match_d) begin
            match_cnt_q <= match_cnt_q + 4'd1;
            if (match_cnt_q == 4'(MATCH_CNT-1)) begin
              ok_q    <= ok_q | mask_d;
              state_q <= NEXT;
            end
          end else begin
            match_cnt_q <= '0;
            if (slip_cnt_q == 3'd6) begin
              fail_q  <= fail_q | mask_d;
              state_q <= NEXT;
            end else begin
              slip_q  <= mask_d;
              state_q <= SLIP;
            end
          end
        end
        SLIP: begin
          slip_q     <= '0;
          slip_cnt_q <= slip_cnt_q + 3'd1;
          wait_cnt_q <= 4'(SLIP_WAIT-1);
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_q == '0) state_q <= CHECK;
          else wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        NEXT: begin
          if (last_d) begin
`ifdef LVDS_ALIGN_RETRY_EN
            if (|fail_q && retry_q != 2'd3) begin
              retry_q     <= retry_q + 2'd1;
              ok_q        <= '0;
              fail_q      <= '0;
              cur_lane_q  <= '0;
              slip_cnt_q  <= '0;
              match_cnt_q <= '0;
              state_q     <= CHECK;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
`else
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`endif
          end else begin
            cur_lane_q  <= cur_lane_q + 3'd1;
            slip_cnt_q  <= '0;
            match_cnt_q <= '0;
            state_q     <= CHECK;
          end
        end
        DONE: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slip       = slip_q;
  assign cur_lane   = cur_lane_q;
  assign align_busy = busy_q;
  assign align_done = done_q;
  assign lane_ok    = ok_q;
  assign lane_fail  = fail_q;
`ifdef LVDS_ALIGN_RETRY_EN
  assign retry_cnt  = retry_q;
`endif

endmodule
